// File: rtl/reservation_station_if.sv
// Shared micro-architectural types and the dispatch/CDB/issue bundle of the reservation station.
// Dispatch, CDB and functional unit drive through master; the station itself binds to slave.
package uarch_pkg;
  parameter int unsigned PIPE_WIDTH = 2;
  parameter int unsigned TAG_WIDTH  = 6;

  typedef struct packed {
    logic                 rdy;
    logic [TAG_WIDTH-1:0] tag;
    logic [31:0]          data;
  } operand_t;

  typedef struct packed {
    logic [TAG_WIDTH-1:0] rob_tag;
    logic [7:0]           opcode;
    operand_t             src1;
    operand_t             src2;
  } instruction_t;
endpackage

interface reservation_station_if #(
  parameter int unsigned NUM_CDB = 2
);
  import uarch_pkg::*;

  logic                               flush;
  logic [PIPE_WIDTH-1:0]              rs_rdy;
  logic [PIPE_WIDTH-1:0]              rs_we;
  instruction_t [PIPE_WIDTH-1:0]      rs_entries;
  logic [NUM_CDB-1:0]                 cdb_valid;
  logic [NUM_CDB-1:0][TAG_WIDTH-1:0]  cdb_tag;
  logic [NUM_CDB-1:0][31:0]           cdb_data;
  logic                               issue_valid;
  logic                               issue_rdy;
  instruction_t                       issue_inst;

  modport master (
    output flush, rs_we, rs_entries, cdb_valid, cdb_tag, cdb_data, issue_rdy,
    input  rs_rdy, issue_valid, issue_inst
  );

  modport slave (
    input  flush, rs_we, rs_entries, cdb_valid, cdb_tag, cdb_data, issue_rdy,
    output rs_rdy, issue_valid, issue_inst
  );
endinterface

// File: rtl/reservation_station.sv
// Per-class issue queue: buffers renamed instructions, snoops the CDB for operands and
// issues the oldest ready entry each cycle using an age matrix.
module reservation_station
  import uarch_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned NUM_CDB     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  reservation_station_if.slave  rs_if
);

  localparam int unsigned IdxW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int unsigned CntW = $clog2(NUM_ENTRIES + 1);

  typedef logic [NUM_CDB-1:0][TAG_WIDTH-1:0] cdb_tag_t;
  typedef logic [NUM_CDB-1:0][31:0]          cdb_data_t;

  logic [NUM_ENTRIES-1:0]                   r_valid;
  instruction_t                             r_entry [NUM_ENTRIES];
  // r_age[i][j] set means entry i is older than entry j
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0]  r_age;
  logic [CntW-1:0]                          r_count;

  logic [NUM_ENTRIES-1:0]                   w_valid_d;
  instruction_t                             w_entry_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0]  w_age_d;
  logic [CntW-1:0]                          w_count_d;

  logic [NUM_ENTRIES-1:0]                   w_rdy;
  logic [NUM_ENTRIES-1:0]                   w_is_oldest;
  logic                                     w_sel_found;
  logic [IdxW-1:0]                          w_sel;
  logic                                     w_fire;

  logic                                     w_f0_found;
  logic                                     w_f1_found;
  logic [IdxW-1:0]                          w_f0;
  logic [IdxW-1:0]                          w_f1;
  logic                                     w_alloc0;
  logic                                     w_alloc1;
  logic [IdxW-1:0]                          w_idx0;
  logic [IdxW-1:0]                          w_idx1;

  function automatic operand_t wake_op(input operand_t op, input logic [NUM_CDB-1:0] vld,
                                       input cdb_tag_t tags, input cdb_data_t data);
    operand_t res;
    res = op;
    for (int p = 0; p < NUM_CDB; p++) begin
      if (!res.rdy && vld[p] && (res.tag == tags[p])) begin
        res.rdy  = 1'b1;
        res.data = data[p];
      end
    end
    return res;
  endfunction

  function automatic instruction_t wake_inst(input instruction_t inst,
                                             input logic [NUM_CDB-1:0] vld,
                                             input cdb_tag_t tags, input cdb_data_t data);
    instruction_t res;
    res      = inst;
    res.src1 = wake_op(inst.src1, vld, tags, data);
    res.src2 = wake_op(inst.src2, vld, tags, data);
    return res;
  endfunction

  // Occupancy is the registered count only; slots freed this cycle are not advertised.
  assign rs_if.rs_rdy[0] = (32'(r_count) < NUM_ENTRIES);
  assign rs_if.rs_rdy[1] = ((32'(r_count) + 32'd2) <= NUM_ENTRIES);

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_rdy[i] = r_valid[i] & r_entry[i].src1.rdy & r_entry[i].src2.rdy;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_is_oldest[i] = w_rdy[i];
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if ((j != i) && w_rdy[j] && !r_age[i][j]) begin
          w_is_oldest[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_sel_found = 1'b0;
    w_sel       = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (w_is_oldest[i]) begin
        w_sel_found = 1'b1;
        w_sel       = IdxW'(i);
      end
    end
  end

  assign w_fire            = w_sel_found & rs_if.issue_rdy;
  assign rs_if.issue_valid = w_sel_found;
  assign rs_if.issue_inst  = w_sel_found ? r_entry[w_sel] : '0;

  always_comb begin
    w_f0_found = 1'b0;
    w_f1_found = 1'b0;
    w_f0       = '0;
    w_f1       = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!r_valid[i]) begin
        if (!w_f0_found) begin
          w_f0_found = 1'b1;
          w_f0       = IdxW'(i);
        end else if (!w_f1_found) begin
          w_f1_found = 1'b1;
          w_f1       = IdxW'(i);
        end
      end
    end
  end

  // Slot 1 takes the second free slot only when slot 0 also writes; excess writes are dropped.
  assign w_alloc0 = rs_if.rs_we[0] & w_f0_found;
  assign w_idx0   = w_f0;
  assign w_alloc1 = rs_if.rs_we[1] & (rs_if.rs_we[0] ? w_f1_found : w_f0_found);
  assign w_idx1   = rs_if.rs_we[0] ? w_f1 : w_f0;

  always_comb begin
    w_valid_d = r_valid;
    w_age_d   = r_age;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_entry_d[i] = wake_inst(r_entry[i], rs_if.cdb_valid, rs_if.cdb_tag, rs_if.cdb_data);
    end

    if (w_fire) begin
      w_valid_d[w_sel] = 1'b0;
    end

    // Slot 0 is applied before slot 1 so slot 1 ends up younger than slot 0.
    if (w_alloc0) begin
      w_valid_d[w_idx0] = 1'b1;
      w_entry_d[w_idx0] = wake_inst(rs_if.rs_entries[0], rs_if.cdb_valid, rs_if.cdb_tag,
                                    rs_if.cdb_data);
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        w_age_d[w_idx0][j] = 1'b0;
        w_age_d[j][w_idx0] = (IdxW'(j) != w_idx0);
      end
    end

    if (w_alloc1) begin
      w_valid_d[w_idx1] = 1'b1;
      w_entry_d[w_idx1] = wake_inst(rs_if.rs_entries[1], rs_if.cdb_valid, rs_if.cdb_tag,
                                    rs_if.cdb_data);
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        w_age_d[w_idx1][j] = 1'b0;
        w_age_d[j][w_idx1] = (IdxW'(j) != w_idx1);
      end
    end

    w_count_d = r_count + CntW'(w_alloc0) + CntW'(w_alloc1) - CntW'(w_fire);
  end

  always_ff @(posedge clk) begin
    if (rst || rs_if.flush) begin
      r_valid <= '0;
      r_age   <= '0;
      r_count <= '0;
    end else begin
      r_valid <= w_valid_d;
      r_age   <= w_age_d;
      r_count <= w_count_d;
    end
  end

  // Payload needs no reset: it is only observable through a valid bit.
  always_ff @(posedge clk) begin
    r_entry <= w_entry_d;
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station: issue order, CDB wakeup,
// occupancy back-pressure, age ordering after slot reuse, and flush.
module tb_reservation_station;
  import uarch_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  reservation_station_if #(.NUM_CDB(2)) u_if ();

  reservation_station #(
    .NUM_ENTRIES (8),
    .NUM_CDB     (2)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .rs_if (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic instruction_t mk(input int tag, input logic r1, input int t1,
                                      input logic r2, input int t2);
    instruction_t x;
    x           = '0;
    x.rob_tag   = TAG_WIDTH'(tag);
    x.opcode    = 8'h11;
    x.src1.rdy  = r1;
    x.src1.tag  = TAG_WIDTH'(t1);
    x.src1.data = r1 ? (32'hA000_0000 | 32'(tag)) : 32'd0;
    x.src2.rdy  = r2;
    x.src2.tag  = TAG_WIDTH'(t2);
    x.src2.data = r2 ? (32'hB000_0000 | 32'(tag)) : 32'd0;
    return x;
  endfunction

  task automatic idle_inputs();
    u_if.rs_we     = 2'b00;
    u_if.cdb_valid = 2'b00;
    u_if.flush     = 1'b0;
  endtask

  // Dispatch must never write more entries than advertised free.
  always @(posedge clk) begin
    if (!rst && !u_if.flush) begin
      if (u_if.rs_we == 2'b11) assert (u_if.rs_rdy[1]) else $error("protocol: two writes");
      if (u_if.rs_we != 2'b00) assert (u_if.rs_rdy[0]) else $error("protocol: write when full");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst             = 1'b1;
    u_if.flush      = 1'b0;
    u_if.rs_we      = 2'b00;
    u_if.rs_entries = '0;
    u_if.cdb_valid  = 2'b00;
    u_if.cdb_tag    = '0;
    u_if.cdb_data   = '0;
    u_if.issue_rdy  = 1'b0;

    // Reset
    tick();
    tick();
    rst = 1'b0;
    check("rst_rs_rdy", 32'(u_if.rs_rdy), 32'd3);
    check("rst_issue_valid", 32'(u_if.issue_valid), 32'd0);
    check("rst_issue_inst", {31'd0, |u_if.issue_inst}, 32'd0);

    // Two ready instructions in one cycle issue oldest first
    u_if.issue_rdy     = 1'b1;
    u_if.rs_entries[0] = mk(5, 1'b1, 0, 1'b1, 0);
    u_if.rs_entries[1] = mk(6, 1'b1, 0, 1'b1, 0);
    u_if.rs_we         = 2'b11;
    tick();
    idle_inputs();
    check("pair_valid0", 32'(u_if.issue_valid), 32'd1);
    check("pair_tag0", 32'(u_if.issue_inst.rob_tag), 32'd5);
    check("pair_data0", u_if.issue_inst.src1.data, 32'hA000_0005);
    tick();
    check("pair_valid1", 32'(u_if.issue_valid), 32'd1);
    check("pair_tag1", 32'(u_if.issue_inst.rob_tag), 32'd6);
    tick();
    check("pair_empty", 32'(u_if.issue_valid), 32'd0);
    check("pair_rs_rdy", 32'(u_if.rs_rdy), 32'd3);

    // Wakeup of src1 via CDB port 1 two cycles after the write
    u_if.rs_entries[0] = mk(10, 1'b0, 3, 1'b1, 0);
    u_if.rs_we         = 2'b01;
    tick();
    idle_inputs();
    check("wake_wait0", 32'(u_if.issue_valid), 32'd0);
    tick();
    u_if.cdb_valid   = 2'b10;
    u_if.cdb_tag[1]  = TAG_WIDTH'(3);
    u_if.cdb_data[1] = 32'hDEAD_BEEF;
    check("wake_wait1", 32'(u_if.issue_valid), 32'd0);
    tick();
    idle_inputs();
    check("wake_valid", 32'(u_if.issue_valid), 32'd1);
    check("wake_tag", 32'(u_if.issue_inst.rob_tag), 32'd10);
    check("wake_src1_data", u_if.issue_inst.src1.data, 32'hDEAD_BEEF);
    check("wake_src1_rdy", 32'(u_if.issue_inst.src1.rdy), 32'd1);
    tick();
    check("wake_drained", 32'(u_if.issue_valid), 32'd0);

    // CDB broadcast in the allocate cycle is captured
    u_if.rs_entries[0] = mk(11, 1'b1, 0, 1'b0, 9);
    u_if.rs_we         = 2'b01;
    u_if.cdb_valid     = 2'b01;
    u_if.cdb_tag[0]    = TAG_WIDTH'(9);
    u_if.cdb_data[0]   = 32'h0000_1234;
    tick();
    idle_inputs();
    check("alloc_wake_valid", 32'(u_if.issue_valid), 32'd1);
    check("alloc_wake_tag", 32'(u_if.issue_inst.rob_tag), 32'd11);
    check("alloc_wake_src2", u_if.issue_inst.src2.data, 32'h0000_1234);
    tick();
    check("alloc_wake_drained", 32'(u_if.issue_valid), 32'd0);

    // Fill to capacity with the FU stalled
    u_if.issue_rdy = 1'b0;
    for (int p = 0; p < 3; p++) begin
      u_if.rs_entries[0] = mk(20 + 2 * p, 1'b1, 0, 1'b1, 0);
      u_if.rs_entries[1] = mk(21 + 2 * p, 1'b1, 0, 1'b1, 0);
      u_if.rs_we         = 2'b11;
      tick();
      idle_inputs();
      check("fill_stall_tag", 32'(u_if.issue_inst.rob_tag), 32'd20);
    end
    check("fill6_rs_rdy", 32'(u_if.rs_rdy), 32'd3);
    u_if.rs_entries[0] = mk(26, 1'b1, 0, 1'b1, 0);
    u_if.rs_we         = 2'b01;
    tick();
    idle_inputs();
    check("fill7_rs_rdy", 32'(u_if.rs_rdy), 32'd1);
    u_if.rs_entries[0] = '0;
    u_if.rs_entries[1] = mk(27, 1'b1, 0, 1'b1, 0);
    u_if.rs_we         = 2'b10;
    tick();
    idle_inputs();
    check("fill8_rs_rdy", 32'(u_if.rs_rdy), 32'd0);
    check("fill8_tag", 32'(u_if.issue_inst.rob_tag), 32'd20);
    u_if.issue_rdy = 1'b1;
    tick();
    u_if.issue_rdy = 1'b0;
    check("free1_rs_rdy", 32'(u_if.rs_rdy), 32'd1);
    check("free1_tag", 32'(u_if.issue_inst.rob_tag), 32'd21);

    // Reused slot 0 must be youngest despite its low index
    u_if.rs_entries[0] = mk(28, 1'b1, 0, 1'b1, 0);
    u_if.rs_we         = 2'b01;
    u_if.issue_rdy     = 1'b1;
    tick();
    idle_inputs();
    check("net_delta_rs_rdy", 32'(u_if.rs_rdy), 32'd1);
    for (int k = 0; k < 7; k++) begin
      check("age_order_tag", 32'(u_if.issue_inst.rob_tag), (k < 6) ? 32'(22 + k) : 32'd28);
      tick();
    end
    check("age_drained", 32'(u_if.issue_valid), 32'd0);
    check("age_rs_rdy", 32'(u_if.rs_rdy), 32'd3);

    // Flush beats same-cycle writes and clears waiting entries
    u_if.issue_rdy = 1'b0;
    for (int p = 0; p < 2; p++) begin
      u_if.rs_entries[0] = mk(30 + 2 * p, 1'b0, 40, 1'b1, 0);
      u_if.rs_entries[1] = mk(31 + 2 * p, 1'b0, 40, 1'b1, 0);
      u_if.rs_we         = 2'b11;
      tick();
      idle_inputs();
    end
    check("held4_valid", 32'(u_if.issue_valid), 32'd0);
    u_if.rs_entries[0] = mk(50, 1'b1, 0, 1'b1, 0);
    u_if.rs_entries[1] = mk(51, 1'b1, 0, 1'b1, 0);
    u_if.rs_we         = 2'b11;
    u_if.flush         = 1'b1;
    tick();
    idle_inputs();
    check("flush_rs_rdy", 32'(u_if.rs_rdy), 32'd3);
    check("flush_valid", 32'(u_if.issue_valid), 32'd0);
    u_if.cdb_valid   = 2'b01;
    u_if.cdb_tag[0]  = TAG_WIDTH'(40);
    u_if.cdb_data[0] = 32'h4040_4040;
    tick();
    idle_inputs();
    check("flush_no_stale", 32'(u_if.issue_valid), 32'd0);

    // Counter restarted from zero after flush
    for (int p = 0; p < 3; p++) begin
      u_if.rs_entries[0] = mk(2 * p + 1, 1'b1, 0, 1'b1, 0);
      u_if.rs_entries[1] = mk(2 * p + 2, 1'b1, 0, 1'b1, 0);
      u_if.rs_we         = 2'b11;
      tick();
      idle_inputs();
    end
    check("post_flush6_rs_rdy", 32'(u_if.rs_rdy), 32'd3);
    u_if.rs_entries[0] = mk(7, 1'b1, 0, 1'b1, 0);
    u_if.rs_we         = 2'b01;
    tick();
    idle_inputs();
    check("post_flush7_rs_rdy", 32'(u_if.rs_rdy), 32'd1);
    u_if.issue_rdy = 1'b1;
    for (int k = 0; k < 7; k++) begin
      check("post_flush_order", 32'(u_if.issue_inst.rob_tag), 32'(k + 1));
      tick();
    end
    check("final_empty", 32'(u_if.issue_valid), 32'd0);
    check("final_rs_rdy", 32'(u_if.rs_rdy), 32'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
